muldiv_16: RTL
==============

MULDIV_16 -- requirements
Module: muldiv_16

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 16 bits by the constant MD_DW in mycpu_pkg.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start_in  input  1  request a new operation; sampled only in IDLE.
REQ-005 op_in  input  2  operation of type muldiv_op_t: 00 MUL (low half), 01 MULH (unsigned high half), 10 DIVU (quotient), 11 REMU (remainder).
REQ-006 a_in  input  16  multiplicand or dividend, captured with start_in.
REQ-007 b_in  input  16  multiplier or divisor, captured with start_in.
REQ-008 busy_out  output  1  high whenever the state is not IDLE.
REQ-009 ready_out  output  1  one-cycle pulse marking a valid result_out.
REQ-010 result_out  output  16  result, which feeds the write-back 3:1 16-bit select as its d2 input.
REQ-011 dz_out  output  1  divide-by-zero flag for the last completed DIVU/REMU; 0 after MUL/MULH.

Function
REQ-012 The FSM SHALL have three states, IDLE, CALC and DONE, held as muldiv_state_t.
REQ-013 In IDLE with start_in=1, the next edge SHALL capture op_in, a_in and b_in, clear the step counter, and enter CALC.
REQ-014 In CALC, each cycle SHALL perform one step (unsigned shift-add multiply, or restoring divide) and increment the 4-bit step counter.
REQ-015 When the counter equals 15, CALC SHALL perform its 16th step and then enter DONE.
REQ-016 DONE SHALL last exactly one cycle with ready_out=1, then return to IDLE.
REQ-017 ready_out SHALL be asserted in the 17th cycle after the cycle in which start_in was sampled.
REQ-018 Exception: a DIVU/REMU with b=0 SHALL go IDLE->DONE directly, so ready_out is asserted in the 1st cycle after sampling.
REQ-019 Divide-by-zero results: DIVU SHALL return 0xFFFF, REMU SHALL return the captured a, and dz_out SHALL be 1.
REQ-020 MUL SHALL return product[15:0] and MULH SHALL return product[31:16] of the unsigned 32-bit product.
REQ-021 The internal product and accumulator registers SHALL be 32 bits, with no overflow flag.
REQ-022 result_out and dz_out SHALL update only on entry to DONE and hold until the next completion.
REQ-023 start_in SHALL be ignored while in CALC or DONE, with no queuing.
REQ-024 A start_in in the IDLE cycle immediately following DONE SHALL be accepted (back-to-back operation).
REQ-025 op_in, a_in and b_in changing after capture SHALL NOT affect the operation in flight.

Reset
REQ-026 Asserting rst at any time, including mid-CALC, SHALL force IDLE with counter=0, busy_out=0, ready_out=0, result_out=0x0000 and dz_out=0.
REQ-027 Reset SHALL take effect without waiting for a clock edge, and the in-flight operation SHALL be discarded.
REQ-028 The first start_in SHALL be accepted on the first edge after rst deasserts.

Structure
REQ-029 mycpu_pkg SHALL hold muldiv_op_t, muldiv_state_t, MD_DW=16 and MD_STEPS=16.
REQ-030 The RTL SHALL be a single module with no datapath sub-module.
REQ-031 A companion assertion module, muldiv_16_svamod (simulation only), SHALL X-check every port.
REQ-032 muldiv_16_svamod SHALL assert that ready_out is a single-cycle pulse.
REQ-033 muldiv_16_svamod SHALL assert that ready_out only follows busy_out.

Verification
REQ-034 MUL a=0x0003, b=0x0005 -> ready_out at cycle 17, result_out=0x000F, dz_out=0.
REQ-035 MUL, then MULH, each with a=0xFFFF, b=0xFFFF, issued back-to-back -> results 0x0001 then 0xFFFE, with the second start accepted in the cycle after the first ready_out.
REQ-036 DIVU a=100, b=7 -> 0x000E; REMU with the same operands -> 0x0002, dz_out=0.
REQ-037 DIVU a=0x1234, b=0 -> ready_out at cycle 1, result_out=0xFFFF, dz_out=1; REMU with the same operands -> 0x1234, dz_out=1.
REQ-038 Reset mid-operation: start MUL, raise rst during cycle 8 -> busy_out=0 and result_out=0x0000 immediately; after release, a new MUL 2x2 -> 0x0004 at cycle 17.
REQ-039 Busy rejection: pulse start_in with different operands during CALC -> ignored, and the original result is returned unchanged.

Source files
------------

// File: rtl/mycpu_pkg.sv
// rtl/mycpu_pkg.sv - shared types and constants for the iterative multiply/divide unit
package mycpu_pkg;

   localparam int MD_DW    = 16;
   localparam int MD_STEPS = 16;
   localparam int MD_CW    = $clog2(MD_STEPS);

   typedef enum logic [1:0] {
      OP_MUL  = 2'b00,
      OP_MULH = 2'b01,
      OP_DIVU = 2'b10,
      OP_REMU = 2'b11
   } muldiv_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } muldiv_state_t;

   // Both divide flavours share the restoring datapath; op bit 1 selects it.
   function automatic logic is_div(muldiv_op_t op);
      return op[1];
   endfunction

endpackage

// File: rtl/muldiv_16_svamod.sv
// rtl/muldiv_16_svamod.sv - simulation-only port checks for muldiv_16
module muldiv_16_svamod
   import mycpu_pkg::*;
(
   input logic             clk,
   input logic             rst,
   input logic             start_in,
   input muldiv_op_t       op_in,
   input logic [MD_DW-1:0] a_in,
   input logic [MD_DW-1:0] b_in,
   input logic             busy_out,
   input logic             ready_out,
   input logic [MD_DW-1:0] result_out,
   input logic             dz_out
);

   a_rst_known: assert property (@(posedge clk) !$isunknown(rst));

   a_ports_known: assert property (@(posedge clk) disable iff (rst)
      !$isunknown({start_in, op_in, a_in, b_in, busy_out, ready_out, result_out, dz_out}));

   a_ready_pulse: assert property (@(posedge clk) disable iff (rst)
      ready_out |=> !ready_out);

   a_ready_busy: assert property (@(posedge clk) disable iff (rst)
      ready_out |-> busy_out);

endmodule

// File: rtl/muldiv_16.sv
// rtl/muldiv_16.sv - 16-step unsigned shift-add multiplier and restoring divider
module muldiv_16
   import mycpu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start_in,
   input  muldiv_op_t       op_in,
   input  logic [MD_DW-1:0] a_in,
   input  logic [MD_DW-1:0] b_in,
   output logic             busy_out,
   output logic             ready_out,
   output logic [MD_DW-1:0] result_out,
   output logic             dz_out
);

   localparam logic [MD_CW-1:0] CNT_LAST = MD_CW'(MD_STEPS - 1);

   muldiv_state_t      state;
   muldiv_op_t         op_q;
   logic [MD_CW-1:0]   cnt;
   // acc: product accumulator or partial remainder; sh: shifted multiplicand or dividend/quotient
   logic [2*MD_DW-1:0] acc;
   logic [2*MD_DW-1:0] sh;
   logic [MD_DW-1:0]   bq;

   logic [2*MD_DW-1:0] acc_n;
   logic [2*MD_DW-1:0] sh_n;
   logic [2*MD_DW-1:0] rs;
   logic [MD_DW-1:0]   bq_n;
   logic [MD_DW-1:0]   res_n;
   logic               ge;

   always_comb begin
      rs    = {acc[2*MD_DW-2:0], sh[MD_DW-1]};
      ge    = (rs >= {{MD_DW{1'b0}}, bq});
      acc_n = acc;
      sh_n  = sh;
      bq_n  = bq;
      if (is_div(op_q)) begin
         acc_n = ge ? (rs - {{MD_DW{1'b0}}, bq}) : rs;
         sh_n  = {{MD_DW{1'b0}}, sh[MD_DW-2:0], ge};
      end else begin
         acc_n = acc + (bq[0] ? sh : '0);
         sh_n  = sh << 1;
         bq_n  = bq >> 1;
      end
      // The result is taken from the step being performed on the final edge.
      case (op_q)
         OP_MUL:  res_n = acc_n[MD_DW-1:0];
         OP_MULH: res_n = acc_n[2*MD_DW-1:MD_DW];
         OP_DIVU: res_n = sh_n[MD_DW-1:0];
         default: res_n = acc_n[MD_DW-1:0];
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         op_q       <= OP_MUL;
         cnt        <= '0;
         acc        <= '0;
         sh         <= '0;
         bq         <= '0;
         busy_out   <= 1'b0;
         ready_out  <= 1'b0;
         result_out <= '0;
         dz_out     <= 1'b0;
      end else begin
         ready_out <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_in) begin
                  op_q     <= op_in;
                  cnt      <= '0;
                  acc      <= '0;
                  sh       <= {{MD_DW{1'b0}}, a_in};
                  bq       <= b_in;
                  busy_out <= 1'b1;
                  // Divide by zero skips the iteration entirely.
                  if (is_div(op_in) && (b_in == '0)) begin
                     state      <= ST_DONE;
                     ready_out  <= 1'b1;
                     dz_out     <= 1'b1;
                     result_out <= (op_in == OP_DIVU) ? '1 : a_in;
                  end else begin
                     state <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               acc <= acc_n;
               sh  <= sh_n;
               bq  <= bq_n;
               cnt <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  state      <= ST_DONE;
                  ready_out  <= 1'b1;
                  result_out <= res_n;
                  dz_out     <= 1'b0;
               end
            end
            ST_DONE: begin
               state    <= ST_IDLE;
               busy_out <= 1'b0;
            end
            default: begin
               state    <= ST_IDLE;
               busy_out <= 1'b0;
            end
         endcase
      end
   end

endmodule
